// File: rtl/onehot_span_decoder_if.sv
// Result bus between the priority encoder and its span decoder.
// The slave side is the decoder; the master side is whoever feeds
// one-hot pairs in and consumes decoded results.
interface onehot_span_decoder_if #(
  parameter int WIDTH = 5
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int LEN_W = $clog2(WIDTH + 1);

  // Input pair from the encoder
  logic [WIDTH-1:0] data_left_i;
  logic [WIDTH-1:0] data_right_i;
  logic             data_val_i;
  logic             data_ready_o;

  // Decoded result to downstream
  logic [IDX_W-1:0] left_idx_o;
  logic [IDX_W-1:0] right_idx_o;
  logic [WIDTH-1:0] span_mask_o;
  logic [LEN_W-1:0] span_len_o;
  logic             zero_o;
  logic             err_o;
  logic             data_val_o;
  logic             data_ready_i;

  modport master (
    output data_left_i,
    output data_right_i,
    output data_val_i,
    input  data_ready_o,
    input  left_idx_o,
    input  right_idx_o,
    input  span_mask_o,
    input  span_len_o,
    input  zero_o,
    input  err_o,
    input  data_val_o,
    output data_ready_i
  );

  modport slave (
    input  data_left_i,
    input  data_right_i,
    input  data_val_i,
    output data_ready_o,
    output left_idx_o,
    output right_idx_o,
    output span_mask_o,
    output span_len_o,
    output zero_o,
    output err_o,
    output data_val_o,
    input  data_ready_i
  );
endinterface

// File: rtl/onehot_span_decoder.sv
// Decodes a leftmost/rightmost one-hot pair from the priority encoder into
// binary indices, a contiguous span mask and a span length.
// Two registered stages with valid/ready flow control:
//   p1: one-hot legality, index encode, zero/err classification
//   p2: span mask and span length, drives the result bus
module onehot_span_decoder #(
  parameter int WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  onehot_span_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int LEN_W = $clog2(WIDTH + 1);

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // OR-encode of a one-hot vector. Only meaningful for a legal one-hot input;
  // illegal inputs are flagged as errors and their index is discarded.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Ones from bit r up to bit l inclusive.
  function automatic logic [WIDTH-1:0] span_mask(input logic [IDX_W-1:0] l,
                                                 input logic [IDX_W-1:0] r);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (IDX_W'(i) >= r) && (IDX_W'(i) <= l);
    end
    return m;
  endfunction

  // l - r + 1, computed at LEN_W so a full-width span does not wrap.
  function automatic logic [LEN_W-1:0] span_len(input logic [IDX_W-1:0] l,
                                                input logic [IDX_W-1:0] r);
    return LEN_W'(l) - LEN_W'(r) + LEN_W'(1);
  endfunction

  // Stage p1 registers
  logic             vld_p1_q,       vld_p1_d;
  logic [IDX_W-1:0] left_idx_p1_q,  left_idx_p1_d;
  logic [IDX_W-1:0] right_idx_p1_q, right_idx_p1_d;
  logic             zero_p1_q,      zero_p1_d;
  logic             err_p1_q,       err_p1_d;

  // Stage p2 registers (drive the result bus)
  logic             vld_p2_q,       vld_p2_d;
  logic [IDX_W-1:0] left_idx_p2_q,  left_idx_p2_d;
  logic [IDX_W-1:0] right_idx_p2_q, right_idx_p2_d;
  logic [WIDTH-1:0] span_mask_p2_q, span_mask_p2_d;
  logic [LEN_W-1:0] span_len_p2_q,  span_len_p2_d;
  logic             zero_p2_q,      zero_p2_d;
  logic             err_p2_q,       err_p2_d;

  // Handshake
  logic s1_load;
  logic s2_load;
  logic in_ready;
  logic in_fire;

  // Stage p1 classification of the incoming pair
  logic             left_oh;
  logic             right_oh;
  logic             both_zero;
  logic [IDX_W-1:0] left_raw;
  logic [IDX_W-1:0] right_raw;
  logic             zero_c;
  logic             err_c;
  logic             ok_c;
  logic             ok_p1;

  // Flow control: each stage advances when it is empty or the stage after it
  // is advancing, so a full pipeline shifts with no bubble.
  always_comb begin
    s2_load  = !vld_p2_q || bus.data_ready_i;
    s1_load  = !vld_p1_q || s2_load;
    in_ready = !srst_i && s1_load;
    in_fire  = bus.data_val_i && in_ready;
  end

  // Legality checks and index encode of the incoming pair.
  always_comb begin
    left_oh   = is_onehot(bus.data_left_i);
    right_oh  = is_onehot(bus.data_right_i);
    both_zero = (bus.data_left_i == '0) && (bus.data_right_i == '0);
    left_raw  = onehot_to_idx(bus.data_left_i);
    right_raw = onehot_to_idx(bus.data_right_i);
    zero_c    = both_zero;
    // A lone zero vector fails the one-hot test, so it lands here as well.
    err_c     = !both_zero && (!left_oh || !right_oh || (left_raw < right_raw));
    ok_c      = !zero_c && !err_c;
  end

  // ---- stage p0 -> p1 ----
  // Next state for p1: capture a new pair on input transfer, else hold.
  always_comb begin
    vld_p1_d       = vld_p1_q;
    left_idx_p1_d  = left_idx_p1_q;
    right_idx_p1_d = right_idx_p1_q;
    zero_p1_d      = zero_p1_q;
    err_p1_d       = err_p1_q;
    if (s1_load) vld_p1_d = in_fire;
    if (in_fire) begin
      left_idx_p1_d  = ok_c ? left_raw  : '0;
      right_idx_p1_d = ok_c ? right_raw : '0;
      zero_p1_d      = zero_c;
      err_p1_d       = err_c;
    end
  end

  // ---- stage p1 -> p2 ----
  // Next state for p2: build mask and length from the p1 indices. Zero and
  // error results carry idx 0/0, which would otherwise decode to a one-bit
  // span, so the mask and length are forced to zero for them.
  always_comb begin
    ok_p1          = !zero_p1_q && !err_p1_q;
    vld_p2_d       = vld_p2_q;
    left_idx_p2_d  = left_idx_p2_q;
    right_idx_p2_d = right_idx_p2_q;
    span_mask_p2_d = span_mask_p2_q;
    span_len_p2_d  = span_len_p2_q;
    zero_p2_d      = zero_p2_q;
    err_p2_d       = err_p2_q;
    if (s2_load) vld_p2_d = vld_p1_q;
    if (s2_load && vld_p1_q) begin
      left_idx_p2_d  = left_idx_p1_q;
      right_idx_p2_d = right_idx_p1_q;
      span_mask_p2_d = ok_p1 ? span_mask(left_idx_p1_q, right_idx_p1_q) : '0;
      span_len_p2_d  = ok_p1 ? span_len(left_idx_p1_q, right_idx_p1_q)  : '0;
      zero_p2_d      = zero_p1_q;
      err_p2_d       = err_p1_q;
    end
  end

  // Valid bits and the visible result registers; reset drops in-flight pairs
  // and clears the result bus.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_p1_q       <= 1'b0;
      vld_p2_q       <= 1'b0;
      left_idx_p2_q  <= '0;
      right_idx_p2_q <= '0;
      span_mask_p2_q <= '0;
      span_len_p2_q  <= '0;
      zero_p2_q      <= 1'b0;
      err_p2_q       <= 1'b0;
    end else begin
      vld_p1_q       <= vld_p1_d;
      vld_p2_q       <= vld_p2_d;
      left_idx_p2_q  <= left_idx_p2_d;
      right_idx_p2_q <= right_idx_p2_d;
      span_mask_p2_q <= span_mask_p2_d;
      span_len_p2_q  <= span_len_p2_d;
      zero_p2_q      <= zero_p2_d;
      err_p2_q       <= err_p2_d;
    end
  end

  // Internal p1 data; only observed when vld_p1_q is set, so no reset needed.
  always_ff @(posedge clk_i) begin
    left_idx_p1_q  <= left_idx_p1_d;
    right_idx_p1_q <= right_idx_p1_d;
    zero_p1_q      <= zero_p1_d;
    err_p1_q       <= err_p1_d;
  end

  assign bus.data_ready_o = in_ready;
  assign bus.data_val_o   = vld_p2_q;
  assign bus.left_idx_o   = left_idx_p2_q;
  assign bus.right_idx_o  = right_idx_p2_q;
  assign bus.span_mask_o  = span_mask_p2_q;
  assign bus.span_len_o   = span_len_p2_q;
  assign bus.zero_o       = zero_p2_q;
  assign bus.err_o        = err_p2_q;

endmodule

// File: tb/tb_onehot_span_decoder.sv
// Bench for onehot_span_decoder: behavioural scoreboard plus directed vectors.
module tb_onehot_span_decoder;
  localparam int W = 5;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  onehot_span_decoder_if #(.WIDTH(W)) bus();
  onehot_span_decoder #(.WIDTH(W)) dut (.clk_i(clk), .srst_i(srst), .bus(bus));

  typedef struct {
    int l;
    int r;
    int mask;
    int len;
    int zero;
    int err;
    int pcyc;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  exp_t sbq[$];

  // Reference: decode straight from the classification rules.
  function automatic exp_t model(input logic [W-1:0] lv, input logic [W-1:0] rv);
    exp_t e;
    int li;
    int ri;
    e = '{default: 0};
    li = 0;
    ri = 0;
    if (lv == '0 && rv == '0) begin
      e.zero = 1;
    end else if ($countones(lv) != 1 || $countones(rv) != 1) begin
      e.err = 1;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (lv[i]) li = i;
        if (rv[i]) ri = i;
      end
      if (li < ri) begin
        e.err = 1;
      end else begin
        e.l    = li;
        e.r    = ri;
        e.len  = li - ri + 1;
        e.mask = (1 << (li + 1)) - (1 << ri);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [15:0] out_vec();
    return {bus.left_idx_o, bus.right_idx_o, bus.span_mask_o, bus.span_len_o,
            bus.zero_o, bus.err_o};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard compare, every cycle after the first reset edge.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_out  = '0;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_t h;
      int exp_ready;
      int exp_val;
      exp_ready = (!srst && (sbq.size() < 2 || bus.data_ready_i)) ? 1 : 0;
      exp_val   = (sbq.size() > 0 && sbq[0].pcyc <= cyc - 2) ? 1 : 0;
      check("ready_o", int'(bus.data_ready_o), exp_ready);
      check("val_o", int'(bus.data_val_o), exp_val);
      if (prev_hold) check("stall_hold", int'(out_vec()), int'(prev_out));
      if (!srst && bus.data_val_o && bus.data_ready_i && sbq.size() > 0) begin
        h = sbq.pop_front();
        check("sb_left_idx",  int'(bus.left_idx_o),  h.l);
        check("sb_right_idx", int'(bus.right_idx_o), h.r);
        check("sb_mask",      int'(bus.span_mask_o), h.mask);
        check("sb_len",       int'(bus.span_len_o),  h.len);
        check("sb_zero",      int'(bus.zero_o),      h.zero);
        check("sb_err",       int'(bus.err_o),       h.err);
      end
      if (!srst && bus.data_val_i && bus.data_ready_o) begin
        h = model(bus.data_left_i, bus.data_right_i);
        h.pcyc = cyc;
        sbq.push_back(h);
      end
      if (srst) sbq.delete();
      prev_hold = bus.data_val_o && !bus.data_ready_i && !srst;
      prev_out  = out_vec();
    end
  end

  // Present one pair into an empty pipeline and check its decode two cycles on.
  task automatic send_check(input logic [W-1:0] lv, input logic [W-1:0] rv,
                            input int el, input int er, input int em,
                            input int en, input int ez, input int ee);
    bus.data_left_i  = lv;
    bus.data_right_i = rv;
    bus.data_val_i   = 1'b1;
    @(posedge clk); #1;
    bus.data_val_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("dir_val",   int'(bus.data_val_o),  1);
    check("dir_left",  int'(bus.left_idx_o),  el);
    check("dir_right", int'(bus.right_idx_o), er);
    check("dir_mask",  int'(bus.span_mask_o), em);
    check("dir_len",   int'(bus.span_len_o),  en);
    check("dir_zero",  int'(bus.zero_o),      ez);
    check("dir_err",   int'(bus.err_o),       ee);
    @(posedge clk); #1;
  endtask

  // Hold a pair valid until it is accepted (bounded).
  task automatic push_pair(input logic [W-1:0] lv, input logic [W-1:0] rv);
    int waited;
    bus.data_left_i  = lv;
    bus.data_right_i = rv;
    bus.data_val_i   = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.data_ready_o) break;
      waited++;
      if (waited > 50) begin
        check("push_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [W-1:0] lv;
    logic [W-1:0] rv;
    int a;
    int b;

    bus.data_left_i  = '0;
    bus.data_right_i = '0;
    bus.data_val_i   = 1'b0;
    bus.data_ready_i = 1'b1;

    // Pin the reference model against hand-computed values.
    m = model(5'b00100, 5'b00010);
    check("model_a_mask", m.mask, 6);
    check("model_a_len", m.len, 2);
    m = model(5'b10000, 5'b00001);
    check("model_full_mask", m.mask, 31);
    check("model_full_len", m.len, 5);
    m = model(5'b00100, 5'b00000);
    check("model_lone_zero_err", m.err, 1);
    m = model(5'b00000, 5'b00000);
    check("model_zero", m.zero, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_val_o",   int'(bus.data_val_o),   0);
    check("rst_ready_o", int'(bus.data_ready_o), 1);
    check("rst_outputs", int'(out_vec()),        0);
    @(posedge clk); #1;

    // Directed decodes
    send_check(5'b00100, 5'b00010, 2, 1, 5'b00110, 2, 0, 0);
    send_check(5'b10000, 5'b00001, 4, 0, 5'b11111, 5, 0, 0);
    send_check(5'b01000, 5'b01000, 3, 3, 5'b01000, 1, 0, 0);
    send_check(5'b00000, 5'b00000, 0, 0, 0, 0, 1, 0);
    send_check(5'b00011, 5'b00001, 0, 0, 0, 0, 0, 1);
    send_check(5'b00001, 5'b00100, 0, 0, 0, 0, 0, 1);
    send_check(5'b00100, 5'b00000, 0, 0, 0, 0, 0, 1);

    // Back-to-back stream with a 3-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          a = $urandom_range(0, W - 1);
          b = $urandom_range(0, a);
          push_pair(W'(1 << a), W'(1 << b));
        end
        bus.data_val_i = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.data_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_ready_low", int'(bus.data_ready_o), 0);
        check("stall_val_high",  int'(bus.data_val_o),   1);
        @(posedge clk); #1 bus.data_ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset with two pairs in flight
    bus.data_ready_i = 1'b0;
    push_pair(5'b00010, 5'b00001);
    push_pair(5'b10000, 5'b00100);
    bus.data_val_i = 1'b0;
    srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    check("flush_val_o", int'(bus.data_val_o), 0);
    @(posedge clk); #1;
    bus.data_ready_i = 1'b1;
    send_check(5'b00010, 5'b00010, 1, 1, 5'b00010, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    // Randomized legal/illegal traffic with random backpressure and rare resets
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          a = $urandom_range(0, W - 1);
          b = $urandom_range(0, a);
          lv = W'(1 << a);
          rv = W'(1 << b);
        end
        3: begin
          lv = W'($urandom);
          rv = W'($urandom);
        end
        4: begin
          a = $urandom_range(0, W - 2);
          b = $urandom_range(a + 1, W - 1);
          lv = W'(1 << a);
          rv = W'(1 << b);
        end
        default: begin
          a = $urandom_range(0, W - 1);
          lv = $urandom_range(0, 1) ? W'(1 << a) : '0;
          rv = (lv == '0) ? W'(1 << a) : '0;
        end
      endcase
      bus.data_left_i  = lv;
      bus.data_right_i = rv;
      bus.data_val_i   = ($urandom_range(0, 3) != 0);
      bus.data_ready_i = ($urandom_range(0, 3) != 0);
      srst             = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    srst = 1'b0;
    bus.data_val_i   = 1'b0;
    bus.data_ready_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
